// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the system-memory port arbiter.
//   gnt_e               : 2-bit grant encoding (which port owns the memory
//                         bus in a given cycle, or NONE)
//   STARVE_LIMIT_DEF    : default serial wait-cycle threshold used by the
//                         optional starvation guard
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        GNT_VGA  = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_SER  = 2'd2,
        GNT_NONE = 2'd3
    } gnt_e;

    localparam int STARVE_LIMIT_DEF = 15;

endpackage : mem_arb_pkg

// File: rtl/arb_starve_counter.sv
// ----------------------------------------------------------------------------
// arb_starve_counter
// Counts how long the serial port has been kept waiting and raises a promote
// flag once the wait reaches LIMIT. Only instantiated when the arbiter is
// built with MEM_PORT_ARBITER_STARVE_GUARD_EN.
//   Clock      in  : system clock, rising edge
//   Reset      in  : asynchronous, active-high reset
//   i_req      in  : serial request
//   i_ack      in  : serial access on the bus this cycle (clears the count)
//   o_promote  out : serial should outrank CPU in the current arbitration
// ----------------------------------------------------------------------------
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic Clock,
    input  logic Reset,
    input  logic i_req,
    input  logic i_ack,
    output logic o_promote
);

    logic [3:0] r_cnt;

    // Saturating 4-bit wait counter; the ack cycle restarts the count.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_cnt <= 4'd0;
        end else if (i_ack) begin
            r_cnt <= 4'd0;
        end else if (i_req && (r_cnt != 4'hF)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_promote = (int'(r_cnt) >= LIMIT);

endmodule : arb_starve_counter

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous memory between VGA line fetch, CPU
// load/store and the serial bulk loader. Fixed priority VGA > CPU > serial,
// at most one access per cycle, the previous cycle's winner is masked so a
// held request is not granted twice. All memory-side outputs are registered;
// read data comes back two cycles after the request with a per-port strobe.
//
// Optional build macro:
//   MEM_PORT_ARBITER_STARVE_GUARD_EN - serial is promoted above CPU after it
//   has waited STARVE_LIMIT cycles (VGA always stays highest).
//
// Ports:
//   Clock, Reset                  clock / async active-high reset
//   cpu_req/we/addr/wdata         CPU request (held until cpu_ack)
//   cpu_ack, cpu_rvalid           CPU access-on-bus / read-data strobes
//   vga_req/addr                  VGA read request (held until vga_ack)
//   vga_ack, vga_rvalid           VGA strobes
//   ser_req/we/addr/wdata         serial request (held until ser_ack)
//   ser_ack, ser_rvalid           serial strobes
//   rd_data                       shared read data, qualified by *_rvalid
//   Mem_Addr/Write/WData          registered memory-side outputs
//   Mem_RData                     memory read data, one cycle after address
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              Clock,
    input  logic              Reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,

    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic              vga_rvalid,

    input  logic              ser_req,
    input  logic              ser_we,
    input  logic [ADDR_W-1:0] ser_addr,
    input  logic [DATA_W-1:0] ser_wdata,
    output logic              ser_ack,
    output logic              ser_rvalid,

    output logic [DATA_W-1:0] rd_data,

    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_Write,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic [DATA_W-1:0] Mem_RData
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    gnt_e              r_grant;      // port on the memory bus this cycle
    gnt_e              r_rtag0;      // reader whose address is on the bus
    gnt_e              r_rtag1;      // reader whose data is on Mem_RData
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_write;
    logic [DATA_W-1:0] r_mem_wdata;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic              w_vga_elig;
    logic              w_cpu_elig;
    logic              w_ser_elig;
    logic              w_promote;
    gnt_e              w_winner;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;

    // The port that owns the bus this cycle still has its req high while it
    // sees the ack, so it is masked out of this cycle's pick.
    assign w_vga_elig = vga_req && (r_grant != GNT_VGA);
    assign w_cpu_elig = cpu_req && (r_grant != GNT_CPU);
    assign w_ser_elig = ser_req && (r_grant != GNT_SER);

`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
    arb_starve_counter #(
        .LIMIT     (STARVE_LIMIT)
    ) u_starve (
        .Clock     (Clock),
        .Reset     (Reset),
        .i_req     (ser_req),
        .i_ack     (ser_ack),
        .o_promote (w_promote)
    );
`else
    // Strict fixed priority; the comparison is never true and only keeps the
    // limit parameter referenced when the guard is left out.
    assign w_promote = (STARVE_LIMIT < 0);
`endif

    always_comb begin
        w_winner = GNT_NONE;
        if (w_vga_elig) begin
            w_winner = GNT_VGA;
        end else if (w_promote && w_ser_elig) begin
            w_winner = GNT_SER;
        end else if (w_cpu_elig) begin
            w_winner = GNT_CPU;
        end else if (w_ser_elig) begin
            w_winner = GNT_SER;
        end
    end

    always_comb begin
        w_win_we    = 1'b0;
        w_win_addr  = r_mem_addr;
        w_win_wdata = r_mem_wdata;
        case (w_winner)
            GNT_VGA: begin
                w_win_addr = vga_addr;     // VGA is read-only
            end
            GNT_CPU: begin
                w_win_we    = cpu_we;
                w_win_addr  = cpu_addr;
                w_win_wdata = cpu_wdata;
            end
            GNT_SER: begin
                w_win_we    = ser_we;
                w_win_addr  = ser_addr;
                w_win_wdata = ser_wdata;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory-side registers and read-tag pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_grant     <= GNT_NONE;
            r_rtag0     <= GNT_NONE;
            r_rtag1     <= GNT_NONE;
            r_mem_addr  <= '0;
            r_mem_write <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            r_grant     <= w_winner;
            r_mem_write <= w_win_we;
            r_mem_addr  <= w_win_addr;
            r_mem_wdata <= w_win_wdata;
            // Only reads travel down the tag pipe; writes never raise rvalid.
            r_rtag0     <= ((w_winner != GNT_NONE) && !w_win_we) ? w_winner : GNT_NONE;
            r_rtag1     <= r_rtag0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Mem_Addr   = r_mem_addr;
    assign Mem_Write  = r_mem_write;
    assign Mem_WData  = r_mem_wdata;

    assign vga_ack    = (r_grant == GNT_VGA);
    assign cpu_ack    = (r_grant == GNT_CPU);
    assign ser_ack    = (r_grant == GNT_SER);

    assign vga_rvalid = (r_rtag1 == GNT_VGA);
    assign cpu_rvalid = (r_rtag1 == GNT_CPU);
    assign ser_rvalid = (r_rtag1 == GNT_SER);

    // The memory already registers its read data, so it is passed straight
    // through in the strobe cycle; the bus idles at zero otherwise.
    assign rd_data    = (r_rtag1 != GNT_NONE) ? Mem_RData : '0;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a small synchronous memory model.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        Clock;
    logic        Reset;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_ack, cpu_rvalid;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic        vga_ack, vga_rvalid;
    logic        ser_req, ser_we;
    logic [15:0] ser_addr, ser_wdata;
    logic        ser_ack, ser_rvalid;
    logic [15:0] rd_data;
    logic [15:0] Mem_Addr;
    logic        Mem_Write;
    logic [15:0] Mem_WData;
    logic [15:0] Mem_RData;

    int n_cmp;
    int n_err;

    mem_port_arbiter #(
        .ADDR_W       (16),
        .DATA_W       (16),
        .STARVE_LIMIT (15)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rvalid (cpu_rvalid),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_ack    (vga_ack),
        .vga_rvalid (vga_rvalid),
        .ser_req    (ser_req),
        .ser_we     (ser_we),
        .ser_addr   (ser_addr),
        .ser_wdata  (ser_wdata),
        .ser_ack    (ser_ack),
        .ser_rvalid (ser_rvalid),
        .rd_data    (rd_data),
        .Mem_Addr   (Mem_Addr),
        .Mem_Write  (Mem_Write),
        .Mem_WData  (Mem_WData),
        .Mem_RData  (Mem_RData)
    );

    // Single-port synchronous memory: read data one cycle after the address.
    logic [15:0] mem [0:65535];
    always @(posedge Clock) begin
        if (Mem_Write) mem[Mem_Addr] <= Mem_WData;
        Mem_RData <= mem[Mem_Addr];
    end

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        vga_req = 0; vga_addr = 0;
        ser_req = 0; ser_we = 0; ser_addr = 0; ser_wdata = 0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        Reset = 1'b1;
        idle_inputs();
        #12;
        n_cmp++;
        if ({cpu_ack, vga_ack, ser_ack, cpu_rvalid, vga_rvalid, ser_rvalid, Mem_Write} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_strobes: got %b want 0000000",
                     {cpu_ack, vga_ack, ser_ack, cpu_rvalid, vga_rvalid, ser_rvalid, Mem_Write});
        end
        n_cmp++;
        if ({Mem_Addr, Mem_WData, rd_data} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_buses: addr=%h wdata=%h rd=%h want 0", Mem_Addr, Mem_WData, rd_data);
        end
        #6 Reset = 1'b0;
        tick(); tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_cpu_read;
        // Preload 0xBEEF at 0x0040 through the arbiter.
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 16'hBEEF;
        tick();
        n_cmp++;
        if (!(cpu_ack === 1'b1 && Mem_Write === 1'b1)) begin
            n_err++;
            $display("FAIL cpu_preload: ack=%b write=%b want 1 1", cpu_ack, Mem_Write);
        end
        cpu_req = 0; cpu_we = 0;
        tick(); tick();

        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
        tick();
        n_cmp++;
        if (!(cpu_ack === 1'b1 && Mem_Addr === 16'h0040 && Mem_Write === 1'b0 && cpu_rvalid === 1'b0)) begin
            n_err++;
            $display("FAIL cpu_read_c1: ack=%b addr=%h write=%b rvalid=%b want 1 0040 0 0",
                     cpu_ack, Mem_Addr, Mem_Write, cpu_rvalid);
        end
        cpu_req = 0;
        tick();
        n_cmp++;
        if (!(cpu_rvalid === 1'b1 && rd_data === 16'hBEEF && cpu_ack === 1'b0)) begin
            n_err++;
            $display("FAIL cpu_read_c2: rvalid=%b rd=%h ack=%b want 1 beef 0", cpu_rvalid, rd_data, cpu_ack);
        end
        tick();
        n_cmp++;
        if (cpu_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL cpu_read_c3: rvalid=%b want 0", cpu_rvalid);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_write_vs_vga;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0100; cpu_wdata = 16'h1234;
        vga_req = 1; vga_addr = 16'h2000;
        tick();
        n_cmp++;
        if (!(vga_ack === 1'b1 && cpu_ack === 1'b0 && Mem_Addr === 16'h2000 && Mem_Write === 1'b0)) begin
            n_err++;
            $display("FAIL wv_c1: vga_ack=%b cpu_ack=%b addr=%h write=%b want 1 0 2000 0",
                     vga_ack, cpu_ack, Mem_Addr, Mem_Write);
        end
        vga_req = 0;
        tick();
        n_cmp++;
        if (!(cpu_ack === 1'b1 && vga_ack === 1'b0 && Mem_Write === 1'b1 &&
              Mem_WData === 16'h1234 && Mem_Addr === 16'h0100)) begin
            n_err++;
            $display("FAIL wv_c2: cpu_ack=%b vga_ack=%b write=%b wdata=%h addr=%h want 1 0 1 1234 0100",
                     cpu_ack, vga_ack, Mem_Write, Mem_WData, Mem_Addr);
        end
        n_cmp++;
        if (!(vga_rvalid === 1'b1 && cpu_rvalid === 1'b0)) begin
            n_err++;
            $display("FAIL wv_rvalid: vga_rvalid=%b cpu_rvalid=%b want 1 0", vga_rvalid, cpu_rvalid);
        end
        cpu_req = 0; cpu_we = 0;
        tick();
        n_cmp++;
        if ({cpu_rvalid, vga_rvalid, Mem_Write, cpu_ack} !== 4'b0) begin
            n_err++;
            $display("FAIL wv_c3: cpu_rv=%b vga_rv=%b write=%b cpu_ack=%b want 0 0 0 0",
                     cpu_rvalid, vga_rvalid, Mem_Write, cpu_ack);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_stream;
        logic exp_ack;
        vga_req = 1; vga_addr = 16'h0300;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 6) vga_req = 0;
            exp_ack = (c == 1) || (c == 3) || (c == 5);
            n_cmp++;
            if (vga_ack !== exp_ack) begin
                n_err++;
                $display("FAIL stream_c%0d: vga_ack=%b want %b", c, vga_ack, exp_ack);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_ser_write_read;
        ser_req = 1; ser_we = 1; ser_addr = 16'h7FFF; ser_wdata = 16'h00A5;
        tick();
        n_cmp++;
        if (!(ser_ack === 1'b1 && Mem_Write === 1'b1 && Mem_Addr === 16'h7FFF && Mem_WData === 16'h00A5)) begin
            n_err++;
            $display("FAIL ser_wr: ack=%b write=%b addr=%h wdata=%h want 1 1 7fff 00a5",
                     ser_ack, Mem_Write, Mem_Addr, Mem_WData);
        end
        ser_we = 0;  // new request: read back the same word
        tick();
        n_cmp++;
        if (!(ser_ack === 1'b0 && Mem_Write === 1'b0 && ser_rvalid === 1'b0)) begin
            n_err++;
            $display("FAIL ser_gap: ack=%b write=%b rvalid=%b want 0 0 0", ser_ack, Mem_Write, ser_rvalid);
        end
        tick();
        n_cmp++;
        if (!(ser_ack === 1'b1 && Mem_Write === 1'b0)) begin
            n_err++;
            $display("FAIL ser_rd_ack: ack=%b write=%b want 1 0", ser_ack, Mem_Write);
        end
        ser_req = 0;
        tick();
        n_cmp++;
        if (!(ser_rvalid === 1'b1 && rd_data === 16'h00A5 && cpu_rvalid === 1'b0)) begin
            n_err++;
            $display("FAIL ser_rd_data: rvalid=%b rd=%h cpu_rv=%b want 1 00a5 0", ser_rvalid, rd_data, cpu_rvalid);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_starve;
        int first_ser;
        first_ser = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        vga_req = 1; vga_addr = 16'h0020;
        ser_req = 1; ser_we = 0; ser_addr = 16'h0030;
        for (int c = 1; (c <= 100) && (first_ser == 0); c++) begin
            tick();
            if (ser_ack === 1'b1) first_ser = c;
            if (c <= 4) begin
                n_cmp++;
                if (!(vga_ack === c[0] && cpu_ack === !c[0])) begin
                    n_err++;
                    $display("FAIL starve_alt_c%0d: vga_ack=%b cpu_ack=%b want %b %b",
                             c, vga_ack, cpu_ack, c[0], !c[0]);
                end
            end
        end
        n_cmp++;
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
        if (first_ser == 0 || first_ser > 17) begin
            n_err++;
            $display("FAIL starve_guard: first ser_ack cycle=%0d want 1..17", first_ser);
        end
`else
        if (first_ser != 0) begin
            n_err++;
            $display("FAIL starve_strict: ser_ack at cycle %0d want none within 100", first_ser);
        end
`endif
        idle_inputs();
        tick(); tick(); tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_read;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
        tick();
        n_cmp++;
        if (cpu_ack !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_ack: cpu_ack=%b want 1", cpu_ack);
        end
        cpu_req = 0;
        #1 Reset = 1'b1;
        #1;
        n_cmp++;
        if ({cpu_ack, vga_ack, ser_ack, cpu_rvalid, vga_rvalid, ser_rvalid, Mem_Write} !== 7'b0 ||
            {Mem_Addr, Mem_WData, rd_data} !== 48'h0) begin
            n_err++;
            $display("FAIL rst_mid_async: strobes=%b addr=%h wdata=%h rd=%h want all 0",
                     {cpu_ack, vga_ack, ser_ack, cpu_rvalid, vga_rvalid, ser_rvalid, Mem_Write},
                     Mem_Addr, Mem_WData, rd_data);
        end
        @(posedge Clock);
        #3 Reset = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_cmp++;
            if (cpu_rvalid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid_no_rvalid_c%0d: cpu_rvalid=%b want 0", c, cpu_rvalid);
            end
        end
        // Arbiter restarts with no previous-winner mask.
        cpu_req = 1; cpu_addr = 16'h0040;
        tick();
        n_cmp++;
        if (cpu_ack !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_restart: cpu_ack=%b want 1", cpu_ack);
        end
        cpu_req = 0;
        tick();
        n_cmp++;
        if (!(cpu_rvalid === 1'b1 && rd_data === 16'hBEEF)) begin
            n_err++;
            $display("FAIL rst_mid_reread: rvalid=%b rd=%h want 1 beef", cpu_rvalid, rd_data);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_cpu_read();
        test_write_vs_vga();
        test_stream();
        test_ser_write_read();
        test_starve();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mem_port_arbiter
